mul_int_sched: RTL and testbench

- Shares one pipelined 33x33 integer multiplier (Booth encoder plus Wallace tree, fixed latency, no stall) among NREQ requesters.
- Arbitrates requests round-robin and sign- or zero-extends operands to 33 bits.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency.
- Returns results with the requester id through a credit-protected response FIFO, so back-pressure never overflows the non-stallable datapath.

---
 rtl/mul_int_pkg.sv | 24 ++
 rtl/mul_rsp_fifo.sv | 74 +++++++
 rtl/mul_int_sched.sv | 157 +++++++++++++++
 tb/tb_mul_int_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_int_pkg.sv
// Shared types and sizing helpers for the multiplier scheduler.
package mul_int_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int MUL_W      = DW_DEFAULT + 1;
    localparam int PW         = 2 * DW_DEFAULT;
    localparam int ID_W_MAX   = 3;

    // Never returns less than 1 so that single-entry structures still get a real pointer bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_rsp_fifo.sv
// First-word fall-through response FIFO with wrap-around pointers.
module mul_rsp_fifo
    import mul_int_pkg::*;
#(
    parameter int W          = 8,
    parameter int DEPTH      = 4,
    localparam int CNT_W     = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mul_int_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NREQ requesters.
// Credits cover in-flight tags plus queued responses, so the non-stallable datapath never overruns the FIFO.
module mul_int_sched
    import mul_int_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = DW_DEFAULT,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DW-1:0]     req_a,
    input  logic [NREQ*DW-1:0]     req_b,
    input  logic [NREQ-1:0]        req_signed,
    output logic                   mul_valid,
    output logic [DW:0]            mul_a,
    output logic [DW:0]            mul_b,
    input  logic [2*DW+1:0]        mul_p,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [clog2(NREQ)-1:0] rsp_id,
    output logic [2*DW-1:0]        rsp_data
);

    localparam int IW    = clog2(NREQ);
    localparam int IW1   = IW + 1;
    localparam int IDW1  = ID_W_MAX + 1;
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int OW    = clog2(DEPTH + LAT + 1);
    localparam int P_W   = 2 * DW;
    localparam int FW    = IW + P_W;

    logic [IW-1:0]    ptr_q, ptr_d;
    tag_t             tag_q [LAT];
    tag_t             tag_d [LAT];
    tag_t             tag_out;

    logic [IW1-1:0]   arb_sum;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             credit_ok;
    logic             grant;
    logic [OW-1:0]    inflight;
    logic [OW-1:0]    outstanding;

    logic [DW-1:0]    sel_a, sel_b;
    logic             sel_s;

    logic             fifo_push;
    logic [FW-1:0]    fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;

    // First valid requester scanning upward from the pointer, wrapping at NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        arb_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, ptr_q} + IW1'(k);
            if (arb_sum >= IW1'(NREQ)) begin
                arb_sum = arb_sum - IW1'(NREQ);
            end
            if (!gnt_any && req_valid[arb_sum[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = arb_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + OW'(tag_q[k].valid);
        end
    end

    // A pop in this same cycle is deliberately not credited back.
    assign outstanding = OW'(fifo_count) + inflight;
    assign credit_ok   = (outstanding < OW'(DEPTH));
    assign grant       = gnt_any && credit_ok && !reset;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                sel_a = req_a[k*DW +: DW];
                sel_b = req_b[k*DW +: DW];
                sel_s = req_signed[k];
            end
        end
    end

    assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
    assign mul_valid = grant;
    assign mul_a     = grant ? {sel_s & sel_a[DW-1], sel_a} : '0;
    assign mul_b     = grant ? {sel_s & sel_b[DW-1], sel_b} : '0;

    always_comb begin
        tag_d[0].valid = grant;
        tag_d[0].id    = ID_W_MAX'(gnt_idx);
        for (int k = 1; k < LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    // The last tag stage lines up with the product on mul_p.
    assign tag_out    = tag_q[LAT-1];
    assign fifo_push  = tag_out.valid;
    assign fifo_wdata = {tag_out.id[IW-1:0], mul_p[P_W-1:0]};

    mul_rsp_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (rsp_ready),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_rdata[FW-1 -: IW];
    assign rsp_data  = fifo_rdata[P_W-1:0];

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_push && fifo_full));

    // 32x32 products always fit in 64 bits, so the two extra product bits must agree.
    a_tag_sane: assert property (@(posedge clock) disable iff (reset)
        tag_out.valid |-> (({1'b0, tag_out.id} < IDW1'(NREQ)) && (mul_p[P_W+1] == mul_p[P_W])));

endmodule

// File: tb/tb_mul_int_sched.sv
// Scoreboard bench for mul_int_sched with a behavioural multiplier and arbitration reference.
module tb_mul_int_sched;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_a = '0;
    logic [NREQ*DW-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_signed = '0;
    logic                mul_valid;
    logic [DW:0]         mul_a, mul_b;
    logic [2*DW+1:0]     mul_p;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [1:0]          rsp_id;
    logic [2*DW-1:0]     rsp_data;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    mul_int_sched #(
        .NREQ  (NREQ),
        .DW    (DW),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    // External multiplier: signed 33x33 product, LAT register stages.
    function automatic logic [2*DW+1:0] mul_model(input logic [DW:0] x, input logic [DW:0] y);
        logic signed [2*DW+1:0] sx, sy;
        sx = {{(DW+1){x[DW]}}, x};
        sy = {{(DW+1){y[DW]}}, y};
        return sx * sy;
    endfunction

    logic [2*DW+1:0] p_pipe [LAT];
    always @(posedge clock) begin
        p_pipe[0] <= mul_model(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mul_p = p_pipe[LAT-1];

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: grant allowed while granted-but-not-popped < DEPTH; round-robin from pointer.
    int              m_ptr = 0;
    int              m_out = 0;
    int              m_g;
    logic [NREQ-1:0] m_rdy;
    logic [DW:0]     m_ea, m_eb;
    logic            m_mv;
    logic [31:0]     m_a, m_b;
    logic            m_s;

    always @(negedge clock) begin
        if (reset) begin
            m_ptr = 0;
            m_out = 0;
            exp_q.delete();
        end else begin
            m_g = -1;
            if (m_out < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
                end
            end
            m_rdy = '0;
            m_ea  = '0;
            m_eb  = '0;
            m_mv  = 1'b0;
            if (m_g >= 0) begin
                m_rdy[m_g] = 1'b1;
                m_mv = 1'b1;
                m_a  = req_a[m_g*DW +: DW];
                m_b  = req_b[m_g*DW +: DW];
                m_s  = req_signed[m_g];
                m_ea = m_s ? {m_a[31], m_a} : {1'b0, m_a};
                m_eb = m_s ? {m_b[31], m_b} : {1'b0, m_b};
            end
            n_chk++;
            if (req_ready !== m_rdy) begin
                n_err++;
                $display("FAIL arb: req_ready=%b required %b (t=%0t)", req_ready, m_rdy, $time);
            end
            n_chk++;
            if ({mul_valid, mul_a, mul_b} !== {m_mv, m_ea, m_eb}) begin
                n_err++;
                $display("FAIL opnd: valid=%b a=%h b=%h required valid=%b a=%h b=%h",
                         mul_valid, mul_a, mul_b, m_mv, m_ea, m_eb);
            end
            if (m_g >= 0) begin
                exp_q.push_back('{id: m_g, data: ref_prod(m_a, m_b, m_s)});
                m_ptr = (m_g + 1) % NREQ;
                m_out++;
            end
            if (rsp_valid && rsp_ready) m_out--;
        end
    end

    exp_t mon_e;
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_id !== 2'(mon_e.id) || rsp_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL rsp: id=%0d data=%h, required id=%0d data=%h",
                             rsp_id, rsp_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_signed[i]     = s;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic new_ops(input int i);
        set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    endtask

    task automatic refresh(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) new_ops(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic directed(input string nm, input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [32:0] exp_ma, input logic [63:0] exp_d);
        int lat;
        rsp_ready = 1'b1;
        set_req(id, a, b, s);
        req_valid = NREQ'(1) << id;
        @(negedge clock);
        chk({nm, "_grant"}, req_ready, NREQ'(1) << id);
        chk({nm, "_mul_a"}, mul_a, exp_ma);
        tick();
        req_valid = '0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 10);
        chk({nm, "_latency"}, lat, LAT + 1);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_data"}, rsp_data, exp_d);
        tick();
    endtask

    logic [NREQ-1:0] g;
    int              cnt;
    logic            stale;

    initial begin
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_mul_valid", mul_valid, 0);
        chk("reset_mul_a", mul_a, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        tick();
        reset = 1'b0;
        req_valid = '0;
        tick();

        directed("unsigned", 2, 32'hFFFF_FFFF, 32'd2, 1'b0, 33'h0_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE);
        directed("signed", 1, 32'hFFFF_FFFD, 32'd7, 1'b1, 33'h1_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);

        // Pointer sits at 2 here; prime it to 1, then check skip-ahead and wrap.
        new_ops(0);
        new_ops(3);
        req_valid = 4'b0001;
        @(negedge clock); chk("ptr_prime", req_ready, 4'b0001); tick();
        req_valid = 4'b1000;
        new_ops(0);
        @(negedge clock); chk("ptr_hold_3", req_ready, 4'b1000); tick();
        req_valid = 4'b1001;
        new_ops(3);
        @(negedge clock); chk("ptr_wrap_0", req_ready, 4'b0001); tick();
        req_valid = 4'b1000;
        @(negedge clock); chk("ptr_then_3", req_ready, 4'b1000); tick();
        req_valid = '0;
        repeat (6) tick();

        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk("rr_grant", req_ready, NREQ'(1) << (c % NREQ));
            g = req_ready;
            tick();
            refresh(g);
        end
        req_valid = '0;
        repeat (6) tick();

        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            cnt += $countones(req_ready);
            g = req_ready;
            tick();
            refresh(g);
        end
        chk("bp_grants", cnt, DEPTH);
        chk("bp_rsp_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        cnt = 0;
        @(negedge clock);
        cnt += $countones(req_ready);
        tick();
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            cnt += $countones(req_ready);
            g = req_ready;
            tick();
            refresh(g);
        end
        chk("bp_one_more", cnt, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) tick();

        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            g = req_ready;
            tick();
            refresh(g);
        end
        chk("mid_queued", rsp_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("rst_rsp_clear", rsp_valid, 0);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clock);
            stale = stale | rsp_valid;
        end
        chk("rst_no_stale", stale, 0);
        tick();
        new_ops(1);
        new_ops(3);
        req_valid = 4'b1010;
        @(negedge clock);
        chk("rst_first_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        @(negedge clock);
        tick();
        req_valid = '0;
        repeat (6) tick();

        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            g = req_valid & req_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    new_ops(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || rsp_valid); c++) tick();
        @(negedge clock);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_rsp_valid", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "time limit");
    end

endmodule
